// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared PE state type and saturating adder
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } pe_state_t;

    // Operands are carried in a fixed wide container so one function serves every
    // accumulator width up to SAT_MAX_W-2 bits without the sum itself overflowing.
    localparam int SAT_MAX_W = 64;
    typedef logic [SAT_MAX_W-1:0] wide_t;

    // a and b must already be sign- or zero-extended to SAT_MAX_W bits.
    function automatic wide_t sat_add(
        input  wide_t a,
        input  wide_t b,
        input  int    w,
        input  bit    is_signed,
        input  bit    saturate,
        output bit    ovf
    );
        wide_t one;
        wide_t sum;
        wide_t umax;
        wide_t smax;
        wide_t smin;
        wide_t res;
        one  = wide_t'(1);
        sum  = a + b;
        umax = (one << w) - one;
        smax = (one << (w - 1)) - one;
        smin = ~smax;
        res  = sum;
        ovf  = 1'b0;
        if (is_signed) begin
            if ($signed(sum) > $signed(smax)) begin
                ovf = 1'b1;
                if (saturate) res = smax;
            end else if ($signed(sum) < $signed(smin)) begin
                ovf = 1'b1;
                if (saturate) res = smin;
            end
        end else if (sum > umax) begin
            ovf = 1'b1;
            if (saturate) res = umax;
        end
        return res;
    endfunction

endpackage

// File: rtl/systolic_pe_acc_if.sv
// rtl/systolic_pe_acc_if.sv - operand, drain and status bundle of one PE
interface systolic_pe_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int CNT_W  = 8
);
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] in_weight;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] out_weight;
    logic              drain_en;
    logic [ACC_W-1:0]  drain_in;
    logic              drain_in_valid;
    logic [ACC_W-1:0]  drain_out;
    logic              drain_out_valid;
    logic              ovf;
    logic [CNT_W-1:0]  mac_count;

    modport master (
        output clear, in_valid, in_data, in_weight,
        output drain_en, drain_in, drain_in_valid,
        input  out_valid, out_data, out_weight,
        input  drain_out, drain_out_valid, ovf, mac_count
    );

    modport slave (
        input  clear, in_valid, in_data, in_weight,
        input  drain_en, drain_in, drain_in_valid,
        output out_valid, out_data, out_weight,
        output drain_out, drain_out_valid, ovf, mac_count
    );
endinterface

// File: rtl/pe_mac_sat.sv
// rtl/pe_mac_sat.sv - combinational multiply, extend and saturating accumulate
module pe_mac_sat
    import systolic_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] weight_i,
    input  logic [ACC_W-1:0]  acc_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);
    localparam bit SGN = (SIGNED != 0);
    localparam bit SAT = (SATURATE != 0);

    logic [2*DATA_W-1:0] data_ext;
    logic [2*DATA_W-1:0] weight_ext;
    logic [2*DATA_W-1:0] prod;
    wide_t               prod_wide;
    wide_t               acc_wide;
    wide_t               sum_wide;
    bit                  ovf_b;

    // Extending both operands to 2*DATA_W first makes the low half of an
    // unsigned multiply equal to the signed product as well.
    always_comb begin
        data_ext   = {{DATA_W{SGN & data_i[DATA_W-1]}}, data_i};
        weight_ext = {{DATA_W{SGN & weight_i[DATA_W-1]}}, weight_i};
        prod       = data_ext * weight_ext;
        prod_wide  = {{(SAT_MAX_W-2*DATA_W){SGN & prod[2*DATA_W-1]}}, prod};
        acc_wide   = {{(SAT_MAX_W-ACC_W){SGN & acc_i[ACC_W-1]}}, acc_i};
        ovf_b      = 1'b0;
        sum_wide   = sat_add(acc_wide, prod_wide, ACC_W, SGN, SAT, ovf_b);
        sum_o      = sum_wide[ACC_W-1:0];
        ovf_o      = ovf_b;
    end
endmodule

// File: rtl/systolic_pe_acc.sv
// rtl/systolic_pe_acc.sv - output-stationary PE with saturating MAC and drain chain
module systolic_pe_acc
    import systolic_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 24,
    parameter int SIGNED   = 1,
    parameter int SATURATE = 1,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    systolic_pe_acc_if.slave    pe
);
    pe_state_t         state_q;
    logic              fwd_valid_q;
    logic [DATA_W-1:0] fwd_data_q;
    logic [DATA_W-1:0] fwd_weight_q;
    logic [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic [ACC_W-1:0]  drain_q;
    logic              drain_valid_q;

    logic [ACC_W-1:0]  acc_in_d;
    logic [ACC_W-1:0]  sum_d;
    logic              mac_ovf_d;
    logic [CNT_W-1:0]  cnt_inc_d;

    // A clear restarts the tile, so a product taken in the same cycle starts from zero.
    assign acc_in_d  = (pe.clear || state_q != ACCUM) ? '0 : acc_q;
    assign cnt_inc_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    pe_mac_sat #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_mac (
        .data_i   (pe.in_data),
        .weight_i (pe.in_weight),
        .acc_i    (acc_in_d),
        .sum_o    (sum_d),
        .ovf_o    (mac_ovf_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            fwd_valid_q   <= 1'b0;
            fwd_data_q    <= '0;
            fwd_weight_q  <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            drain_q       <= '0;
            drain_valid_q <= 1'b0;
        end else begin
            fwd_valid_q <= pe.in_valid;
            if (pe.in_valid) begin
                fwd_data_q   <= pe.in_data;
                fwd_weight_q <= pe.in_weight;
            end
            drain_valid_q <= 1'b0;

            if (pe.clear) begin
                if (pe.in_valid) begin
                    acc_q   <= sum_d;
                    cnt_q   <= CNT_W'(1);
                    ovf_q   <= mac_ovf_d;
                    state_q <= ACCUM;
                end else begin
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    ovf_q   <= 1'b0;
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (pe.drain_en) begin
                            drain_q       <= acc_q;
                            drain_valid_q <= 1'b1;
                            state_q       <= DRAIN;
                        end else if (pe.in_valid) begin
                            acc_q   <= sum_d;
                            cnt_q   <= CNT_W'(1);
                            ovf_q   <= mac_ovf_d;
                            state_q <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (pe.drain_en) begin
                            drain_q       <= acc_q;
                            drain_valid_q <= 1'b1;
                            state_q       <= DRAIN;
                        end else if (pe.in_valid) begin
                            acc_q <= sum_d;
                            cnt_q <= cnt_inc_d;
                            ovf_q <= ovf_q | mac_ovf_d;
                        end
                    end
                    DRAIN: begin
                        // After the entry edge this PE only relays results from above.
                        if (pe.drain_en) begin
                            drain_q       <= pe.drain_in;
                            drain_valid_q <= pe.drain_in_valid;
                        end else begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign pe.out_valid       = fwd_valid_q;
    assign pe.out_data        = fwd_data_q;
    assign pe.out_weight      = fwd_weight_q;
    assign pe.drain_out       = drain_q;
    assign pe.drain_out_valid = drain_valid_q;
    assign pe.ovf             = ovf_q;
    assign pe.mac_count       = cnt_q;
endmodule

// File: tb/tb_systolic_pe_acc.sv
// tb/tb_systolic_pe_acc.sv - directed bench for systolic_pe_acc
module tb_systolic_pe_acc;
    import systolic_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    systolic_pe_acc_if #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) if_a ();
    systolic_pe_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) if_s ();
    systolic_pe_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) if_w ();
    systolic_pe_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) if_u ();
    systolic_pe_acc_if #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) if_c0 ();
    systolic_pe_acc_if #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) if_c1 ();
    systolic_pe_acc_if #(.DATA_W(8), .ACC_W(24), .CNT_W(8)) if_c2 ();

    systolic_pe_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1), .CNT_W(8))
        u_a (.clk(clk), .reset(reset), .pe(if_a));
    systolic_pe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .CNT_W(8))
        u_s (.clk(clk), .reset(reset), .pe(if_s));
    systolic_pe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0), .CNT_W(8))
        u_w (.clk(clk), .reset(reset), .pe(if_w));
    systolic_pe_acc #(.DATA_W(8), .ACC_W(16), .SIGNED(0), .SATURATE(1), .CNT_W(8))
        u_u (.clk(clk), .reset(reset), .pe(if_u));
    systolic_pe_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1), .CNT_W(8))
        u_c0 (.clk(clk), .reset(reset), .pe(if_c0));
    systolic_pe_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1), .CNT_W(8))
        u_c1 (.clk(clk), .reset(reset), .pe(if_c1));
    systolic_pe_acc #(.DATA_W(8), .ACC_W(24), .SIGNED(1), .SATURATE(1), .CNT_W(8))
        u_c2 (.clk(clk), .reset(reset), .pe(if_c2));

    assign if_c1.drain_in       = if_c0.drain_out;
    assign if_c1.drain_in_valid = if_c0.drain_out_valid;
    assign if_c2.drain_in       = if_c1.drain_out;
    assign if_c2.drain_in_valid = if_c1.drain_out_valid;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        reset = 1'b1;
        if_a.clear = 0; if_a.in_valid = 0; if_a.in_data = 0; if_a.in_weight = 0;
        if_a.drain_en = 0; if_a.drain_in = 0; if_a.drain_in_valid = 0;
        if_s.clear = 0; if_s.in_valid = 0; if_s.in_data = 0; if_s.in_weight = 0;
        if_s.drain_en = 0; if_s.drain_in = 0; if_s.drain_in_valid = 0;
        if_w.clear = 0; if_w.in_valid = 0; if_w.in_data = 0; if_w.in_weight = 0;
        if_w.drain_en = 0; if_w.drain_in = 0; if_w.drain_in_valid = 0;
        if_u.clear = 0; if_u.in_valid = 0; if_u.in_data = 0; if_u.in_weight = 0;
        if_u.drain_en = 0; if_u.drain_in = 0; if_u.drain_in_valid = 0;
        if_c0.clear = 0; if_c0.in_valid = 0; if_c0.in_data = 0; if_c0.in_weight = 0;
        if_c0.drain_en = 0; if_c0.drain_in = 0; if_c0.drain_in_valid = 0;
        if_c1.clear = 0; if_c1.in_valid = 0; if_c1.in_data = 0; if_c1.in_weight = 0;
        if_c1.drain_en = 0;
        if_c2.clear = 0; if_c2.in_valid = 0; if_c2.in_data = 0; if_c2.in_weight = 0;
        if_c2.drain_en = 0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({if_a.out_valid, if_a.out_data, if_a.out_weight} !== 17'd0) begin
            errors++; $display("FAIL reset_fwd got %h exp 0", {if_a.out_valid, if_a.out_data, if_a.out_weight});
        end
        checks++;
        if ({if_a.drain_out_valid, if_a.drain_out, if_a.ovf, if_a.mac_count} !== 34'd0) begin
            errors++; $display("FAIL reset_status got %h exp 0", {if_a.drain_out_valid, if_a.drain_out, if_a.ovf, if_a.mac_count});
        end
        checks++;
        if (u_a.state_q !== IDLE || u_a.acc_q !== 24'd0) begin
            errors++; $display("FAIL reset_state got state %0d acc %0d exp IDLE 0", u_a.state_q, u_a.acc_q);
        end
    endtask

    task automatic test_signed_accum();
        logic [7:0]  d  [3];
        logic [7:0]  w  [3];
        logic [23:0] ea [3];
        d  = '{8'd3, 8'hFE, 8'hF9};
        w  = '{8'd4, 8'd5,  8'hFF};
        ea = '{24'd12, 24'd2, 24'd9};
        for (int i = 0; i < 3; i++) begin
            if_a.in_valid = 1; if_a.in_data = d[i]; if_a.in_weight = w[i];
            tick();
            checks++;
            if (if_a.out_valid !== 1'b1 || if_a.out_data !== d[i] || if_a.out_weight !== w[i]) begin
                errors++; $display("FAIL fwd_%0d got v%b %h %h exp v1 %h %h", i, if_a.out_valid, if_a.out_data, if_a.out_weight, d[i], w[i]);
            end
            checks++;
            if (u_a.acc_q !== ea[i] || if_a.mac_count !== 8'(i + 1)) begin
                errors++; $display("FAIL acc_%0d got %0d cnt %0d exp %0d cnt %0d", i, u_a.acc_q, if_a.mac_count, ea[i], i + 1);
            end
        end
        if_a.in_valid = 0; if_a.in_data = 8'h55;
        tick();
        checks++;
        if (if_a.out_valid !== 1'b0 || if_a.out_data !== 8'hF9 || if_a.ovf !== 1'b0) begin
            errors++; $display("FAIL fwd_hold got v%b %h ovf %b exp v0 f9 ovf 0", if_a.out_valid, if_a.out_data, if_a.ovf);
        end
        if_a.drain_en = 1; if_a.in_valid = 1; if_a.in_data = 8'h11; if_a.in_weight = 8'h22;
        tick();
        checks++;
        if (if_a.drain_out !== 24'd9 || if_a.drain_out_valid !== 1'b1 || if_a.out_data !== 8'h11 || u_a.acc_q !== 24'd9) begin
            errors++; $display("FAIL drain_entry got %0d v%b fwd %h acc %0d exp 9 v1 11 9", if_a.drain_out, if_a.drain_out_valid, if_a.out_data, u_a.acc_q);
        end
        if_a.drain_en = 0; if_a.in_valid = 0;
        tick();
        checks++;
        if (u_a.state_q !== IDLE || u_a.acc_q !== 24'd0 || if_a.mac_count !== 8'd0 || if_a.drain_out_valid !== 1'b0 || if_a.drain_out !== 24'd9) begin
            errors++; $display("FAIL drain_exit got st %0d acc %0d cnt %0d v%b out %0d exp IDLE 0 0 v0 9", u_a.state_q, u_a.acc_q, if_a.mac_count, if_a.drain_out_valid, if_a.drain_out);
        end
    endtask

    task automatic test_saturation();
        logic [15:0] es [3];
        logic [15:0] ew [3];
        logic        eo [3];
        es = '{16'd16129, 16'd32258, 16'd32767};
        ew = '{16'd16129, 16'd32258, 16'hBD03};
        eo = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            if_s.in_valid = 1; if_s.in_data = 8'd127; if_s.in_weight = 8'd127;
            if_w.in_valid = 1; if_w.in_data = 8'd127; if_w.in_weight = 8'd127;
            tick();
            checks++;
            if (u_s.acc_q !== es[i] || if_s.ovf !== eo[i]) begin
                errors++; $display("FAIL sat_%0d got %0d ovf %b exp %0d ovf %b", i, u_s.acc_q, if_s.ovf, es[i], eo[i]);
            end
            checks++;
            if (u_w.acc_q !== ew[i] || if_w.ovf !== eo[i]) begin
                errors++; $display("FAIL wrap_%0d got %h ovf %b exp %h ovf %b", i, u_w.acc_q, if_w.ovf, ew[i], eo[i]);
            end
        end
        if_s.in_valid = 0; if_w.in_valid = 0;
        if_s.clear = 1; if_w.clear = 1;
        tick();
        if_s.clear = 0; if_w.clear = 0;
    endtask

    task automatic test_unsigned();
        logic [15:0] eu [2];
        logic        eo [2];
        eu = '{16'd65025, 16'd65535};
        eo = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            if_u.in_valid = 1; if_u.in_data = 8'd255; if_u.in_weight = 8'd255;
            tick();
            checks++;
            if (u_u.acc_q !== eu[i] || if_u.ovf !== eo[i]) begin
                errors++; $display("FAIL unsigned_%0d got %0d ovf %b exp %0d ovf %b", i, u_u.acc_q, if_u.ovf, eu[i], eo[i]);
            end
        end
        if_u.in_valid = 0;
    endtask

    task automatic test_drain_chain();
        if_c0.in_valid = 1; if_c0.in_data = 8'd2; if_c0.in_weight = 8'd5;
        if_c1.in_valid = 1; if_c1.in_data = 8'd4; if_c1.in_weight = 8'd5;
        if_c2.in_valid = 1; if_c2.in_data = 8'd5; if_c2.in_weight = 8'd6;
        tick();
        if_c0.in_valid = 0; if_c1.in_valid = 0; if_c2.in_valid = 0;
        if_c0.drain_en = 1; if_c1.drain_en = 1; if_c2.drain_en = 1;
        tick();
        checks++;
        if (if_c2.drain_out !== 24'd30 || if_c2.drain_out_valid !== 1'b1) begin
            errors++; $display("FAIL chain_0 got %0d v%b exp 30 v1", if_c2.drain_out, if_c2.drain_out_valid);
        end
        if_c0.drain_en = 0;
        tick();
        checks++;
        if (if_c2.drain_out !== 24'd20 || if_c2.drain_out_valid !== 1'b1) begin
            errors++; $display("FAIL chain_1 got %0d v%b exp 20 v1", if_c2.drain_out, if_c2.drain_out_valid);
        end
        if_c1.drain_en = 0;
        tick();
        checks++;
        if (if_c2.drain_out !== 24'd10 || if_c2.drain_out_valid !== 1'b1) begin
            errors++; $display("FAIL chain_2 got %0d v%b exp 10 v1", if_c2.drain_out, if_c2.drain_out_valid);
        end
        if_c2.drain_en = 0;
        tick();
        checks++;
        if ({u_c0.acc_q, u_c1.acc_q, u_c2.acc_q} !== 72'd0 || {if_c0.mac_count, if_c1.mac_count, if_c2.mac_count} !== 24'd0 || if_c2.drain_out_valid !== 1'b0) begin
            errors++; $display("FAIL chain_done got acc %0d %0d %0d cnt %0d %0d %0d v%b exp all 0", u_c0.acc_q, u_c1.acc_q, u_c2.acc_q, if_c0.mac_count, if_c1.mac_count, if_c2.mac_count, if_c2.drain_out_valid);
        end
    endtask

    task automatic test_clear();
        logic [7:0] d [5];
        logic [7:0] w [5];
        d = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd10};
        w = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd112};
        for (int i = 0; i < 5; i++) begin
            if_w.in_valid = 1; if_w.in_data = d[i]; if_w.in_weight = w[i];
            tick();
        end
        checks++;
        if (u_w.acc_q !== 16'd100 || if_w.ovf !== 1'b1 || if_w.mac_count !== 8'd5) begin
            errors++; $display("FAIL clear_setup got %0d ovf %b cnt %0d exp 100 ovf 1 cnt 5", u_w.acc_q, if_w.ovf, if_w.mac_count);
        end
        if_w.clear = 1; if_w.in_data = 8'd6; if_w.in_weight = 8'd7;
        tick();
        checks++;
        if (u_w.acc_q !== 16'd42 || if_w.mac_count !== 8'd1 || if_w.ovf !== 1'b0 || u_w.state_q !== ACCUM) begin
            errors++; $display("FAIL clear_mac got %0d cnt %0d ovf %b st %0d exp 42 1 0 ACCUM", u_w.acc_q, if_w.mac_count, if_w.ovf, u_w.state_q);
        end
        if_w.in_valid = 0;
        tick();
        checks++;
        if (u_w.acc_q !== 16'd0 || if_w.mac_count !== 8'd0 || u_w.state_q !== IDLE || if_w.drain_out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_only got %0d cnt %0d st %0d v%b exp 0 0 IDLE v0", u_w.acc_q, if_w.mac_count, u_w.state_q, if_w.drain_out_valid);
        end
        if_w.clear = 0;
    endtask

    task automatic test_reset_mid_drain();
        if_a.in_valid = 1; if_a.in_data = 8'd1; if_a.in_weight = 8'd5;
        tick();
        if_a.in_valid = 0; if_a.drain_en = 1;
        tick();
        checks++;
        if (if_a.drain_out !== 24'd5 || u_a.state_q !== DRAIN) begin
            errors++; $display("FAIL pre_reset_drain got %0d st %0d exp 5 DRAIN", if_a.drain_out, u_a.state_q);
        end
        reset = 1; if_a.in_valid = 1; if_a.in_data = 8'h9A; if_a.in_weight = 8'h3C;
        tick();
        checks++;
        if ({if_a.out_valid, if_a.out_data, if_a.out_weight, if_a.drain_out_valid, if_a.drain_out, if_a.ovf, if_a.mac_count} !== 51'd0 || u_a.state_q !== IDLE) begin
            errors++; $display("FAIL reset_drain got fwd %h drain %0d v%b st %0d exp 0 IDLE", if_a.out_data, if_a.drain_out, if_a.drain_out_valid, u_a.state_q);
        end
        reset = 0; if_a.drain_en = 0; if_a.in_data = 8'd2; if_a.in_weight = 8'd3;
        tick();
        if_a.in_valid = 0;
        checks++;
        if (u_a.acc_q !== 24'd6 || if_a.mac_count !== 8'd1 || u_a.state_q !== ACCUM) begin
            errors++; $display("FAIL post_reset_mac got %0d cnt %0d st %0d exp 6 1 ACCUM", u_a.acc_q, if_a.mac_count, u_a.state_q);
        end
    endtask

    initial begin
        init_inputs();
        test_reset();
        test_signed_accum();
        test_saturation();
        test_unsigned();
        test_drain_chain();
        test_clear();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
